// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver (uart_rx_param).
`timescale 1ns / 100ps
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StBrk
    } uart_state_e;

    // Parity modes
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Board clocks per oversample tick; never below 1 so the divider stays sane.
    function automatic int unsigned calc_div(input int unsigned board_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned div;
        div = board_freq / (baud_rate * oversample);
        return (div == 0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV board clocks, restartable.
`timescale 1ns / 100ps
module uart_baud_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_board,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: wrap at DIV-1, or jump to 0 when a frame starts
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_board or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output, parity/framing/overrun
// status and line-break detection.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// three mid-bit samples instead of a single sample.
`timescale 1ns / 100ps
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned BOARD_FREQ = 64,
    parameter int unsigned BAUD_RATE  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_board,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int unsigned DIV  = calc_div(BOARD_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned ScW  = $clog2(OVERSAMPLE);
    localparam int unsigned BcW  = 4;
`ifdef UART_RX_MAJORITY_EN
    // Decision lands on the last of the three votes
    localparam int unsigned SDec = OVERSAMPLE / 2;
`else
    localparam int unsigned SDec = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [ScW-1:0] ScDec  = ScW'(SDec);
    // sc value right after a decision tick; keeps every later decision one bit apart
    localparam logic [ScW-1:0] ScNext = ScW'(SDec + 1);
    localparam logic [ScW-1:0] ScLast = ScW'(OVERSAMPLE - 1);
    localparam logic [BcW-1:0] BcData = BcW'(DATA_BITS - 1);
    localparam logic [BcW-1:0] BcStop = BcW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    logic                 tick;
    logic                 restart;
    logic [ScW-1:0]       sc_q, sc_d;
    logic [BcW-1:0]       bc_q, bc_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 stop_bad_now;
    logic                 bit_val;
    logic                 sample;
    logic                 frame_ok, frame_bad, frame_brk;
    logic                 par_calc, par_err_calc;
    logic                 handshake;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_board or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end
    assign rx_s = rx_sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_board (clk_board),
        .reset_n   (reset_n),
        .restart   (restart),
        .tick      (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [ScW-1:0] ScEarly = ScW'(OVERSAMPLE / 2 - 2);
    localparam logic [ScW-1:0] ScMid   = ScW'(OVERSAMPLE / 2 - 1);
    logic [1:0] vote_q;

    // Capture the two early votes; the third is rx_s at the decision tick
    always_ff @(posedge clk_board or negedge reset_n) begin
        if (!reset_n) begin
            vote_q <= 2'b11;
        end else if (tick) begin
            if (sc_q == ScEarly) vote_q[0] <= rx_s;
            if (sc_q == ScMid)   vote_q[1] <= rx_s;
        end
    end
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign sample    = tick && (sc_q == ScDec);
    assign handshake = data_valid_q && data_ready;

    // Parity check over the assembled word and received parity bit
    always_comb begin
        par_calc = (^shreg_q) ^ par_bit_q;
        if (PARITY == PAR_ODD) begin
            par_err_calc = ~par_calc;
        end else if (PARITY == PAR_EVEN) begin
            par_err_calc = par_calc;
        end else begin
            par_err_calc = 1'b0;
        end
    end

    // Frame FSM next state, sample counting and bit assembly
    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bc_d         = bc_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        stop_bad_d   = stop_bad_q;
        stop_bad_now = stop_bad_q | ~bit_val;
        restart      = 1'b0;
        frame_ok     = 1'b0;
        frame_bad    = 1'b0;
        frame_brk    = 1'b0;

        if (tick && (state_q == StStart || state_q == StData ||
                     state_q == StPar || state_q == StStop)) begin
            sc_d = (sc_q == ScLast) ? '0 : sc_q + ScW'(1);
        end

        case (state_q)
            StIdle: begin
                sc_d       = '0;
                bc_d       = '0;
                par_bit_d  = 1'b0;
                stop_bad_d = 1'b0;
                if (enable && !rx_s) begin
                    state_d = StStart;
                    restart = 1'b1;
                end
            end
            StStart: begin
                if (sample) begin
                    if (bit_val) begin
                        state_d = StIdle;
                        sc_d    = '0;
                    end else begin
                        state_d = StData;
                        sc_d    = ScNext;
                        bc_d    = '0;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    if (MSB_FIRST != 0) begin
                        shreg_d = {shreg_q[DATA_BITS-2:0], bit_val};
                    end else begin
                        shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    end
                    if (bc_q == BcData) begin
                        state_d = (PARITY != PAR_NONE) ? StPar : StStop;
                        sc_d    = ScNext;
                        bc_d    = '0;
                    end else begin
                        bc_d = bc_q + BcW'(1);
                    end
                end
            end
            StPar: begin
                if (sample) begin
                    par_bit_d = bit_val;
                    state_d   = StStop;
                    sc_d      = ScNext;
                    bc_d      = '0;
                end
            end
            StStop: begin
                if (sample) begin
                    if (bc_q == BcStop) begin
                        sc_d = '0;
                        if (!stop_bad_now) begin
                            frame_ok = 1'b1;
                            state_d  = StIdle;
                        end else if ((shreg_q == '0) && !par_bit_q) begin
                            // Line held low through a zero word: a break, not noise
                            frame_brk = 1'b1;
                            state_d   = StBrk;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = StIdle;
                        end
                    end else begin
                        bc_d       = bc_q + BcW'(1);
                        stop_bad_d = stop_bad_now;
                    end
                end
            end
            StBrk: begin
                sc_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disabling aborts the frame silently
        if (!enable) begin
            state_d   = StIdle;
            sc_d      = '0;
            restart   = 1'b0;
            frame_ok  = 1'b0;
            frame_bad = 1'b0;
            frame_brk = 1'b0;
        end
    end

    // Frame FSM and assembly registers
    always_ff @(posedge clk_board or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sc_q       <= '0;
            bc_q       <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            bc_q       <= bc_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    // Output word, handshake and status next state
    always_comb begin
        data_d        = data_q;
        data_valid_d  = data_valid_q;
        parity_err_d  = parity_err_q;
        overrun_d     = overrun_q;
        framing_err_d = frame_bad | frame_brk;

        if (handshake) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
        if (frame_ok) begin
            if (!data_valid_q || handshake) begin
                data_d       = shreg_q;
                parity_err_d = par_err_calc;
                data_valid_d = 1'b1;
            end else begin
                // Consumer stalled: keep the old word, drop the new one
                overrun_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_board or negedge reset_n) begin
        if (!reset_n) begin
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign break_det   = (state_q == StBrk);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: default 8N1 instance plus an even-parity instance.
`timescale 1ns / 100ps
module tb_uart_rx_param;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    localparam int BitCyc = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       data_ready;
    logic       rx0, rx1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1;
    logic       ovr0, ovr1, brk0, brk1, busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vcyc0 = 0, vcyc1 = 0, fcnt0 = 0, fcnt1 = 0;

    always #1 clk = ~clk;

    uart_rx_param dut (
        .clk_board   (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .rx          (rx0),
        .data        (data0),
        .data_valid  (valid0),
        .data_ready  (data_ready),
        .parity_err  (perr0),
        .framing_err (ferr0),
        .overrun     (ovr0),
        .break_det   (brk0),
        .busy        (busy0)
    );

    uart_rx_param #(
        .PARITY (2)
    ) dut_par (
        .clk_board   (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .rx          (rx1),
        .data        (data1),
        .data_valid  (valid1),
        .data_ready  (data_ready),
        .parity_err  (perr1),
        .framing_err (ferr1),
        .overrun     (ovr1),
        .break_det   (brk1),
        .busy        (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then step off the edge before driving
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #0.5;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else rx1 = v;
        step(n);
    endtask

    // Start bit, data MSB first, optional parity, one stop bit, one idle bit
    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic p, input logic stop, input int stop_low);
        drive(which, 1'b0, BitCyc);
        for (int i = 7; i >= 0; i--) drive(which, d[i], BitCyc);
        if (has_par) drive(which, p, BitCyc);
        if (stop) begin
            drive(which, 1'b1, BitCyc);
        end else begin
            drive(which, 1'b0, stop_low);
            drive(which, 1'b1, BitCyc);
        end
        drive(which, 1'b1, BitCyc);
    endtask

    task automatic clear_counts();
        vcyc0 = 0;
        vcyc1 = 0;
        fcnt0 = 0;
        fcnt1 = 0;
    endtask

    // Scoreboard: every accepted word is compared against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (valid0) vcyc0++;
            if (valid1) vcyc1++;
            if (ferr0) fcnt0++;
            if (ferr1) fcnt1++;
            if (valid0 && data_ready) begin
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("dut_data", {24'd0, data0}, {24'd0, e.data});
                    check("dut_perr", {31'd0, perr0}, {31'd0, e.perr});
                end else begin
                    check("dut_extra_word", 32'(q0.size()), 32'd1);
                end
            end
            if (valid1 && data_ready) begin
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("par_data", {24'd0, data1}, {24'd0, e.data});
                    check("par_perr", {31'd0, perr1}, {31'd0, e.perr});
                end else begin
                    check("par_extra_word", 32'(q1.size()), 32'd1);
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        data_ready = 1'b1;
        rx0        = 1'b1;
        rx1        = 1'b1;
        step(5);
        @(negedge clk);
        check("rst_data", {24'd0, data0}, 32'd0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_perr", {31'd0, perr0}, 32'd0);
        check("rst_ferr", {31'd0, ferr0}, 32'd0);
        check("rst_ovr", {31'd0, ovr0}, 32'd0);
        check("rst_brk", {31'd0, brk0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        step(1);
        reset_n = 1'b1;
        step(10);

        // Clean 0xAA with consumer ready
        clear_counts();
        q0.push_back({8'hAA, 1'b0});
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        check("t1_valid_cycles", vcyc0, 1);
        check("t1_ferr_pulses", fcnt0, 0);
        check("t1_ovr", {31'd0, ovr0}, 32'd0);

        // Stalled consumer: second word dropped, overrun raised
        step(1);
        data_ready = 1'b0;
        q0.push_back({8'h55, 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        check("t2_data_kept", {24'd0, data0}, 32'h55);
        check("t2_valid", {31'd0, valid0}, 32'd1);
        check("t2_ovr", {31'd0, ovr0}, 32'd1);
        step(1);
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_valid_clr", {31'd0, valid0}, 32'd0);
        check("t2_ovr_clr", {31'd0, ovr0}, 32'd0);

        // Bad stop bit on non-zero data
        step(1);
        clear_counts();
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b0, 48);
        @(negedge clk);
        check("t3_ferr_pulses", fcnt0, 1);
        check("t3_valid_cycles", vcyc0, 0);
        check("t3_busy", {31'd0, busy0}, 32'd0);

        // Break: line low through a whole frame and five more bits
        step(1);
        clear_counts();
        drive(0, 1'b0, BitCyc * 15);
        @(negedge clk);
        check("brk_det", {31'd0, brk0}, 32'd1);
        check("brk_busy", {31'd0, busy0}, 32'd1);
        check("brk_ferr_pulses", fcnt0, 1);
        step(1);
        drive(0, 1'b1, 6);
        @(negedge clk);
        check("brk_clr", {31'd0, brk0}, 32'd0);
        check("brk_idle", {31'd0, busy0}, 32'd0);
        check("brk_valid_cycles", vcyc0, 0);

        // Start-bit glitch
        step(BitCyc);
        clear_counts();
        rx0 = 1'b0;
        step(5);
        @(negedge clk);
        check("gl_busy", {31'd0, busy0}, 32'd1);
        step(3);
        rx0 = 1'b1;
        step(100);
        @(negedge clk);
        check("gl_idle", {31'd0, busy0}, 32'd0);
        check("gl_valid_cycles", vcyc0, 0);
        check("gl_ferr_pulses", fcnt0, 0);

        // Disable mid-frame
        step(1);
        clear_counts();
        rx0 = 1'b0;
        step(200);
        @(negedge clk);
        check("en_busy_mid", {31'd0, busy0}, 32'd1);
        step(1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_abort_busy", {31'd0, busy0}, 32'd0);
        step(600);
        rx0 = 1'b1;
        step(20);
        enable = 1'b1;
        step(100);
        @(negedge clk);
        check("en_valid_cycles", vcyc0, 0);
        check("en_ferr_pulses", fcnt0, 0);
        check("en_data_kept", {24'd0, data0}, 32'h55);

        // Even parity instance: 0x01 needs parity bit 1
        step(1);
        clear_counts();
        q1.push_back({8'h01, 1'b1});
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1, 0);
        q1.push_back({8'h01, 1'b0});
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("par_valid_cycles", vcyc1, 2);
        check("par_ferr_pulses", fcnt1, 0);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver feeding the VU-meter data path. It provides the following:
- configurable data width, bit order, parity, stop bits and oversampling;
- a valid/ready output handshake;
- parity, framing and overrun status, plus line-break detection.

It sits between the board `rx` pin and the level/VGA logic.

Parameters:
BOARD_FREQ, 64, board clock frequency (same units as BAUD_RATE)
BAUD_RATE, 1, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, >=4
DATA_BITS, 8, data bits per frame, 5..9
MSB_FIRST, 1, 1 = first received data bit lands in data[DATA_BITS-1]; 0 = LSB first
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2

Ports:
clk_board  in  1  board clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  receiver enable; low forces IDLE and aborts any frame
rx  in  1  serial line, idle high, asynchronous to clk_board
data  out  DATA_BITS  received word, stable while data_valid=1
data_valid  out  1  word available
data_ready  in  1  consumer accepts word when data_valid && data_ready
parity_err  out  1  parity mismatch flag travelling with data; valid only when data_valid=1
framing_err  out  1  one-cycle pulse when a stop bit samples 0
overrun  out  1  sticky flag; cleared by reset or by a handshake
break_det  out  1  high while a break condition persists
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: data=0, data_valid=0, parity_err=0, framing_err=0, overrun=0, break_det=0, busy=0. The rx synchroniser flops reset to 1.
- rx passes through a 2-FF synchroniser, called rx_s below.
- Tick divider: DIV = BOARD_FREQ/(BAUD_RATE*OVERSAMPLE).
  - A tick pulses for one cycle when the counter reaches DIV-1.
  - The counter restarts at 0 on the IDLE->START transition.
- Sample counter sc counts ticks within a bit. It is reset at each state change.
- State machine: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: rx_s=0 and enable=1 -> START.
  - START: on the tick where sc=OVERSAMPLE/2-1, sample rx_s. If 1 (glitch), go to IDLE with no output. If 0, go to DATA with sc realigned so all later samples fall mid-bit (every OVERSAMPLE ticks).
  - DATA: sample DATA_BITS bits, placing each per MSB_FIRST. Then go to PAR if PARITY!=0, else STOP.
  - PAR: sample one bit. parity_calc = XOR(data bits) XOR parity bit. Odd parity expects 1; even parity expects 0.
  - STOP: sample STOP_BITS bits.
    - All 1: frame complete, go to IDLE.
    - Any 0 with data all zero, parity bit 0 (or no parity): break. Set break_det=1, pulse framing_err, go to BRK.
    - Any other 0: pulse framing_err, discard the frame, go to IDLE.
  - BRK: stay until rx_s=1, then clear break_det and go to IDLE.
- Delivery: on the cycle after the final stop sample tick, load data and parity_err and set data_valid=1. Latency is 1 cycle.
- Handshake: data_valid stays high until data_valid && data_ready. Handshake clears data_valid and overrun.
- Frame completes while data_valid=1 and data_ready=0: the new word is dropped, old data is kept, overrun is set.
- Frame completes in the same cycle as a handshake: the new word loads, data_valid stays 1, no overrun.
- enable=0 mid-frame: return to IDLE next cycle. Partial data is discarded, no flags, any pending output word is retained.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value is the 2-of-3 majority of rx_s at sample ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. This also applies to the start-bit check.
- Undefined: a single sample at OVERSAMPLE/2-1.

Decomposition:
- Package uart_pkg holds:
  - state enum;
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - function computing DIV from BOARD_FREQ, BAUD_RATE and OVERSAMPLE.
- One sub-module, uart_baud_tick: the divider, with a restart input and a tick output.

Test Plan:
Common settings for all scenarios: defaults, clock period 2 ns (one bit = 128 ns).
- Frame start, bits 1,0,1,0,1,0,1,0, stop 1, data_ready=1 -> data=0xAA, one-cycle data_valid, no flags.
- Bits 0,1,0,1,0,1,0,1 with data_ready=0, then a second frame 0xAA -> data stays 0x55, overrun=1. Raising data_ready clears data_valid and overrun.
- Bits 1,0,1,0,1,0,1,0 with stop 0 -> framing_err pulse, data_valid stays 0.
- All-zero bits, stop 0, line low for a further 5 bits -> framing_err pulse, break_det=1 until rx rises, then busy=0.
- rx low for 8 cycles, then high -> returns to IDLE, no data_valid, no flags.
- PARITY=2, data 0x01, parity bit 0 -> data=0x01, data_valid=1, parity_err=1. Same data with parity bit 1 -> parity_err=0.
